// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port (wr/ad/rd) between NREQ
// write-back sources (ALU result, memory load, I/O input).
//
// Handshake: requester i drives req[i] together with its slices of req_ad and
// req_data and keeps all three stable until it observes gnt[i]=1 after a
// posedge. It may then drop req[i] or present a new request for the next edge.
// The current grantee is excluded from arbitration on the edge where gnt[i] is
// still high, so a single requester that keeps re-requesting is served every
// other cycle.
//
// All write-port outputs are registered on posedge clk. The register file
// samples them on the following negedge, so they are stable by then.
//
// Build option: define REGARB_FIXED_PRIO_EN to select fixed priority, where the
// lowest eligible index wins. There is no rotating pointer in that build. The
// default build uses round-robin arbitration.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 8,
  parameter int AW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_ad,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic                 addr_lock,
  output logic [NREQ-1:0]      gnt,
  output logic                 wr,
  output logic [AW-1:0]        ad,
  output logic [DW-1:0]        rd,
  output logic [(1<<AW)-1:0]   pend
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NREG = 1 << AW;

  logic [NREQ-1:0] elig;
  logic            any_elig;
  logic            take;
  logic [PW-1:0]   win_idx;
  logic [NREQ-1:0] win_onehot;
  logic [AW-1:0]   win_ad;
  logic [DW-1:0]   win_data;

  // The current grantee is masked, so a source is never granted on two
  // consecutive edges for a request it has already been served.
  assign elig     = req & ~gnt;
  assign any_elig = |elig;

  // addr_lock blocks new grants only. Pending requests remain visible on pend.
  assign take = ~addr_lock & any_elig;

`ifdef REGARB_FIXED_PRIO_EN

  // Fixed priority: scan from the highest index down, so the lowest
  // eligible index is the last one written and therefore wins.
  always_comb begin
    win_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig[i]) win_idx = PW'(i);
    end
  end

`else

  logic [PW-1:0] rr_ptr;
  logic          rr_found;

  // Round-robin: search rr_ptr+1, rr_ptr+2, ... (mod NREQ) and take the
  // first eligible index found.
  always_comb begin
    win_idx  = rr_ptr;
    rr_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!rr_found && elig[(int'(rr_ptr) + k) % NREQ]) begin
        rr_found = 1'b1;
        win_idx  = PW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  // The pointer moves to the winner only when a grant is actually issued.
  // Its reset value of NREQ-1 gives req0 top priority on the first grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= PW'(NREQ - 1);
    end else if (take) begin
      rr_ptr <= win_idx;
    end
  end

`endif

  // Select the winner's destination register and data. The result is used
  // only when take=1, and take=1 implies win_idx is in range.
  always_comb begin
    win_onehot = '0;
    win_ad     = '0;
    win_data   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == PW'(i)) begin
        win_onehot[i] = 1'b1;
        win_ad        = req_ad[i*AW +: AW];
        win_data      = req_data[i*DW +: DW];
      end
    end
  end

  // Registered write port. gnt and wr pulse for one cycle per grant.
  // ad and rd hold their last written values between grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt <= '0;
      wr  <= 1'b0;
      ad  <= '0;
      rd  <= '0;
    end else if (take) begin
      gnt <= win_onehot;
      wr  <= 1'b1;
      ad  <= win_ad;
      rd  <= win_data;
    end else begin
      gnt <= '0;
      wr  <= 1'b0;
    end
  end

  // Pending-write mask for decode-stage stalls. A register is flagged while
  // any active, not-yet-granted request targets it. The mask ignores addr_lock.
  always_comb begin
    pend = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int r = 0; r < NREG; r++) begin
        if (req[i] && !gnt[i] && (req_ad[i*AW +: AW] == AW'(r))) begin
          pend[r] = 1'b1;
        end
      end
    end
  end

endmodule
